// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents:
//   state_e   - sequencer states IDLE/START/RUN/DONE (2-bit encoding)
//   op_e      - latched operation, OP_MULT=0, OP_DIV=1
//   DEF_*     - default timeout, exception register index and exception codes
//   exc_code  - selects the rstatus value written for a failed operation
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int DEF_MAX_CYCLES  = 40;
  localparam int DEF_RSTATUS_REG = 30;
  localparam int DEF_EXC_MULT    = 4;
  localparam int DEF_EXC_DIV     = 5;

  function automatic logic [31:0] exc_code(input op_e op, input int exc_mult, input int exc_div);
    return (op == OP_DIV) ? 32'(exc_div) : 32'(exc_mult);
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Bundle of every signal between the multiply/divide sequencer and its
// surroundings (X stage, shared MD unit, writeback port).
// Modports:
//   master - the sequencer: consumes dx_*, flush, md_ready/exception/result,
//            wb_accept; drives md_ctrl_*, md_op_*, stall, busy, wb_*, timeout_err
//   slave  - the pipeline/unit side, directions reversed
interface multdiv_ctrl_if;

  // X-stage issue
  logic        dx_valid;
  logic        dx_is_mult;
  logic        dx_is_div;
  logic [4:0]  dx_rd;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic        flush;

  // MD unit
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;

  // pipeline control and writeback
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_accept;
  logic        timeout_err;

  modport master (
    input  dx_valid, dx_is_mult, dx_is_div, dx_rd, dx_a, dx_b, flush,
    input  md_ready, md_exception, md_result, wb_accept,
    output md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b,
    output stall, busy, wb_valid, wb_rd, wb_data, timeout_err
  );

  modport slave (
    output dx_valid, dx_is_mult, dx_is_div, dx_rd, dx_a, dx_b, flush,
    output md_ready, md_exception, md_result, wb_accept,
    input  md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b,
    input  stall, busy, wb_valid, wb_rd, wb_data, timeout_err
  );

endinterface

// File: rtl/multdiv_timeout_ctr.sv
// 8-bit RUN-cycle counter for the multiply/divide timeout guard.
// Ports:
//   clk, reset_n - clock, synchronous active-low reset
//   clr          - zero the count (takes priority over en)
//   en           - advance the count by one
//   tc           - count has reached MAX_CYCLES-1
module multdiv_timeout_ctr #(
  parameter int MAX_CYCLES = 40
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VALUE = 8'(MAX_CYCLES - 1);

  logic [7:0] count;

  // NOTE: clocked state is always written with <= so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // The sequencer leaves RUN on terminal count, so the counter never wraps.
  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiplier/divider.
// Takes a MUL/DIV from the X stage, latches operands and destination, pulses
// the unit start for one cycle, stalls the front of the pipe while the unit
// runs, and presents a single writeback beat held until wb_accept.
// Ports:
//   clk, reset_n - clock, synchronous active-low reset (overrides everything)
//   bus          - multdiv_ctrl_if.master: X-stage issue, flush, MD unit
//                  handshake, stall/busy, writeback beat, sticky timeout_err
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int RSTATUS_REG = DEF_RSTATUS_REG,
  parameter int EXC_MULT    = DEF_EXC_MULT,
  parameter int EXC_DIV     = DEF_EXC_DIV
) (
  input logic           clk,
  input logic           reset_n,
  multdiv_ctrl_if.master bus
);

  state_e      state;
  op_e         op_q;
  logic [4:0]  rd_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        start_mult_q;
  logic        start_div_q;
  logic        busy_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        timeout_q;

  logic        dx_start;
  logic        tc;
  logic [31:0] exc_value;

  assign dx_start  = bus.dx_valid & (bus.dx_is_mult | bus.dx_is_div) & ~bus.flush;
  assign exc_value = exc_code(op_q, EXC_MULT, EXC_DIV);

  multdiv_timeout_ctr #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == START),
    .en      (state == RUN),
    .tc      (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_q         <= OP_MULT;
      rd_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      busy_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      // Start flags only ever live for the single START cycle.
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (dx_start) begin
            op_a_q       <= bus.dx_a;
            op_b_q       <= bus.dx_b;
            rd_q         <= bus.dx_rd;
            op_q         <= bus.dx_is_mult ? OP_MULT : OP_DIV;
            start_mult_q <= bus.dx_is_mult;
            start_div_q  <= ~bus.dx_is_mult;
            busy_q       <= 1'b1;
            state        <= START;
          end
        end

        START: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (bus.md_ready) begin
            // A result on the terminal-count cycle is still a normal completion.
            wb_valid_q <= 1'b1;
            if (bus.md_exception) begin
              wb_rd_q   <= 5'(RSTATUS_REG);
              wb_data_q <= exc_value;
            end else begin
              wb_rd_q   <= rd_q;
              wb_data_q <= bus.md_result;
            end
            state <= DONE;
          end else if (tc) begin
            timeout_q  <= 1'b1;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= 5'(RSTATUS_REG);
            wb_data_q  <= exc_value;
            state      <= DONE;
          end
        end

        DONE: begin
          // wb_rd/wb_data stay put after the beat; they are qualified by wb_valid.
          if (bus.flush || bus.wb_accept) begin
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // A flush arriving in START must suppress the pulse in that same cycle, so
  // the registered start flags are gated by flush on the way out.
  assign bus.md_ctrl_mult = start_mult_q & ~bus.flush;
  assign bus.md_ctrl_div  = start_div_q & ~bus.flush;
  assign bus.md_op_a      = op_a_q;
  assign bus.md_op_b      = op_b_q;

  // In IDLE the stall must hold the issuing instruction in X the same cycle,
  // and in DONE it drops in the accept cycle so the pipe restarts promptly.
  assign bus.stall = (state == IDLE) ? dx_start :
                     (state == DONE) ? ~bus.wb_accept : 1'b1;

  assign bus.busy        = busy_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl. Stimulus pushes the expected
// writeback beat into a queue; a negedge monitor pops and compares it on each
// accepted beat. Control outputs are checked inline by the stimulus tasks.
module tb_multdiv_ctrl;

  localparam int MAX_CYCLES = 40;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  multdiv_ctrl_if bus();

  multdiv_ctrl #(
    .MAX_CYCLES  (MAX_CYCLES),
    .RSTATUS_REG (30),
    .EXC_MULT    (4),
    .EXC_DIV     (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        tmo;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted writeback beat must match the queue head.
  always @(negedge clk) begin
    wb_exp_t e;
    if (reset_n && bus.wb_valid && bus.wb_accept) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got beat rd=%0d data=0x%0h, expected no beat",
                 bus.wb_rd, bus.wb_data);
      end else begin
        e = sb.pop_front();
        check("sb_wb_rd",   32'(bus.wb_rd),       32'(e.rd));
        check("sb_wb_data", bus.wb_data,          e.data);
        check("sb_timeout", 32'(bus.timeout_err), 32'(e.tmo));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.md_ctrl_mult || bus.md_ctrl_div) pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // IDLE issue cycle plus START cycle; returns at the start of RUN cycle 1.
  task automatic start_op(input bit div, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input string tag);
    bus.dx_valid   = 1'b1;
    bus.dx_is_mult = !div;
    bus.dx_is_div  = div;
    bus.dx_rd      = rd;
    bus.dx_a       = a;
    bus.dx_b       = b;
    @(negedge clk);
    check({tag, "_stall_issue"}, 32'(bus.stall), 1);
    cyc();
    bus.dx_valid   = 1'b0;
    bus.dx_is_mult = 1'b0;
    bus.dx_is_div  = 1'b0;
    @(negedge clk);
    check({tag, "_start_pulse"}, 32'(div ? bus.md_ctrl_div : bus.md_ctrl_mult), 1);
    check({tag, "_other_pulse"}, 32'(div ? bus.md_ctrl_mult : bus.md_ctrl_div), 0);
    check({tag, "_op_a"}, bus.md_op_a, a);
    check({tag, "_op_b"}, bus.md_op_b, b);
    check({tag, "_busy_start"}, 32'(bus.busy), 1);
    cyc();
  endtask

  // Full operation: md_ready on RUN cycle ready_cyc (0 = never), then hold
  // wb_accept low for 'hold' DONE cycles before accepting.
  task automatic run_op(input bit div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input int ready_cyc, input bit exc, input logic [31:0] res,
                        input int hold, input logic [4:0] exp_rd,
                        input logic [31:0] exp_data, input bit exp_tmo, input string tag);
    int p0;
    int done_run;
    wb_exp_t e;
    p0       = pulses;
    done_run = (ready_cyc > 0) ? ready_cyc : MAX_CYCLES;
    start_op(div, rd, a, b, tag);
    e.rd   = exp_rd;
    e.data = exp_data;
    e.tmo  = exp_tmo;
    sb.push_back(e);
    for (int c = 1; c <= done_run; c++) begin
      bus.md_ready     = (c == ready_cyc);
      bus.md_exception = exc;
      bus.md_result    = res;
      if (c == done_run) begin
        @(negedge clk);
        check({tag, "_last_run_valid"}, 32'(bus.wb_valid), 0);
        check({tag, "_last_run_stall"}, 32'(bus.stall), 1);
      end
      cyc();
    end
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = '0;
    for (int h = 0; h < hold; h++) begin
      bus.wb_accept = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.wb_valid), 1);
      check({tag, "_hold_rd"},    32'(bus.wb_rd), 32'(exp_rd));
      check({tag, "_hold_data"},  bus.wb_data, exp_data);
      check({tag, "_hold_stall"}, 32'(bus.stall), 1);
      cyc();
    end
    bus.wb_accept = 1'b1;
    @(negedge clk);
    check({tag, "_accept_valid"}, 32'(bus.wb_valid), 1);
    check({tag, "_accept_stall"}, 32'(bus.stall), 0);
    cyc();
    bus.wb_accept = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"},  32'(bus.busy), 0);
    check({tag, "_idle_valid"}, 32'(bus.wb_valid), 0);
    check({tag, "_one_pulse"},  32'(pulses - p0), 1);
    check({tag, "_timeout"},    32'(bus.timeout_err), 32'(exp_tmo));
    cyc();
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.dx_valid     = 1'b0;
    bus.dx_is_mult   = 1'b0;
    bus.dx_is_div    = 1'b0;
    bus.dx_rd        = '0;
    bus.dx_a         = '0;
    bus.dx_b         = '0;
    bus.flush        = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = '0;
    bus.wb_accept    = 1'b0;
    repeat (2) cyc();

    // Reset state
    check("rst_busy",     32'(bus.busy), 0);
    check("rst_stall",    32'(bus.stall), 0);
    check("rst_wb_valid", 32'(bus.wb_valid), 0);
    check("rst_wb_rd",    32'(bus.wb_rd), 0);
    check("rst_wb_data",  bus.wb_data, 0);
    check("rst_timeout",  32'(bus.timeout_err), 0);
    check("rst_pulses",   32'({bus.md_ctrl_mult, bus.md_ctrl_div}), 0);
    check("rst_op_a",     bus.md_op_a, 0);
    reset_n = 1'b1;
    cyc();

    // Basic multiply, result on RUN cycle 17
    run_op(1'b0, 5'd3, 32'd7, 32'd6, 17, 1'b0, 32'd42, 0, 5'd3, 32'd42, 1'b0, "mul");
    // Divide by zero -> exception to rstatus
    run_op(1'b1, 5'd7, 32'd10, 32'd0, 3, 1'b1, 32'hFFFF_FFFF, 0, 5'd30, 32'd5, 1'b0, "div0");
    // Writeback backpressure for 4 cycles
    run_op(1'b0, 5'd9, 32'd100, 32'd3, 2, 1'b0, 32'd300, 4, 5'd9, 32'd300, 1'b0, "bp");
    // md_ready on the terminal-count cycle wins over timeout
    run_op(1'b0, 5'd5, 32'd1, 32'd2, MAX_CYCLES, 1'b0, 32'h1234, 0, 5'd5, 32'h1234, 1'b0, "edge");
    // Timeout: md_ready never comes
    run_op(1'b0, 5'd4, 32'd8, 32'd9, 0, 1'b0, 32'd0, 1, 5'd30, 32'd4, 1'b1, "tmo");
    // timeout_err stays set; rd=0 still produces a beat
    run_op(1'b1, 5'd0, 32'd20, 32'd4, 5, 1'b0, 32'hDEAD, 0, 5'd0, 32'hDEAD, 1'b1, "sticky");

    // Flush in IDLE blocks the start
    bus.dx_valid   = 1'b1;
    bus.dx_is_mult = 1'b1;
    bus.flush      = 1'b1;
    @(negedge clk);
    check("fidle_stall", 32'(bus.stall), 0);
    cyc();
    bus.dx_valid   = 1'b0;
    bus.dx_is_mult = 1'b0;
    bus.flush      = 1'b0;
    @(negedge clk);
    check("fidle_busy",  32'(bus.busy), 0);
    check("fidle_pulse", 32'(bus.md_ctrl_mult), 0);
    cyc();

    // Flush in START suppresses the pulse
    bus.dx_valid   = 1'b1;
    bus.dx_is_mult = 1'b1;
    bus.dx_rd      = 5'd11;
    cyc();
    bus.dx_valid   = 1'b0;
    bus.dx_is_mult = 1'b0;
    bus.flush      = 1'b1;
    @(negedge clk);
    check("fstart_pulse", 32'(bus.md_ctrl_mult), 0);
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    check("fstart_busy", 32'(bus.busy), 0);
    cyc();

    // Flush at RUN cycle 5, late md_ready 3 cycles later
    start_op(1'b1, 5'd6, 32'd50, 32'd7, "frun");
    repeat (4) cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    check("frun_busy",  32'(bus.busy), 0);
    check("frun_valid", 32'(bus.wb_valid), 0);
    check("frun_stall", 32'(bus.stall), 0);
    cyc();
    cyc();
    bus.md_ready  = 1'b1;
    bus.md_result = 32'd7;
    bus.wb_accept = 1'b1;
    cyc();
    bus.md_ready  = 1'b0;
    @(negedge clk);
    check("flate_valid", 32'(bus.wb_valid), 0);
    check("flate_busy",  32'(bus.busy), 0);
    cyc();
    bus.wb_accept = 1'b0;
    cyc();

    // Reset while in DONE, then back-to-back issue
    start_op(1'b0, 5'd12, 32'd3, 32'd4, "rdone");
    bus.md_ready  = 1'b1;
    bus.md_result = 32'd12;
    cyc();
    bus.md_ready  = 1'b0;
    @(negedge clk);
    check("rdone_valid_pre", 32'(bus.wb_valid), 1);
    reset_n = 1'b0;
    cyc();
    check("rdone_valid",   32'(bus.wb_valid), 0);
    check("rdone_busy",    32'(bus.busy), 0);
    check("rdone_stall",   32'(bus.stall), 0);
    check("rdone_wb_rd",   32'(bus.wb_rd), 0);
    check("rdone_wb_data", bus.wb_data, 0);
    check("rdone_timeout", 32'(bus.timeout_err), 0);
    check("rdone_op_a",    bus.md_op_a, 0);
    check("rdone_op_b",    bus.md_op_b, 0);
    reset_n = 1'b1;
    run_op(1'b0, 5'd13, 32'd5, 32'd5, 4, 1'b0, 32'd25, 0, 5'd13, 32'd25, 1'b0, "b2b");

    repeat (3) cyc();
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer for the shared multi-cycle multiplier/divider unit in the 5-stage pipeline.
- Accepts a MULT/DIV instruction from the X stage, latches its operands and destination, and issues a one-cycle start pulse to the unit.
- Stalls the pipeline while the unit runs, captures the result or exception, and presents one writeback beat, held until the writeback port accepts it.
- Provides a timeout guard and flush abort.

Parameters:
- MAX_CYCLES, 40, cycles allowed in RUN before a timeout is declared (range 2..255)
- RSTATUS_REG, 30, register index written on exception
- EXC_MULT, 4, rstatus value for multiply overflow
- EXC_DIV, 5, rstatus value for divide exception

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- dx_valid  in  1  X-stage instruction valid
- dx_is_mult  in  1  X-stage instruction is MUL
- dx_is_div  in  1  X-stage instruction is DIV (mutually exclusive with dx_is_mult)
- dx_rd  in  5  destination register of X-stage instruction
- dx_a  in  32  operand A
- dx_b  in  32  operand B
- flush  in  1  pipeline flush; aborts any operation
- md_ready  in  1  unit result valid (single-cycle pulse)
- md_exception  in  1  unit exception, qualified by md_ready
- md_result  in  32  unit result, qualified by md_ready
- wb_accept  in  1  writeback port grant
- md_ctrl_mult  out  1  one-cycle start pulse, multiply
- md_ctrl_div  out  1  one-cycle start pulse, divide
- md_op_a  out  32  latched operand A, stable START..RUN
- md_op_b  out  32  latched operand B
- stall  out  1  freeze F/D/X stages
- busy  out  1  state != IDLE
- wb_valid  out  1  writeback beat valid
- wb_rd  out  5  writeback destination
- wb_data  out  32  writeback data
- timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (reset_n=0 at clk edge):
  - State goes to IDLE.
  - All outputs, latched operands, counter and timeout_err go to 0.
  - Reset overrides flush and every other input, including mid-operation.
- dx_start = dx_valid & (dx_is_mult | dx_is_div) & ~flush.
- States: IDLE, START, RUN, DONE.
- IDLE:
  - If dx_start: latch dx_a, dx_b, dx_rd and the op (mult/div); go to START.
  - stall = dx_start (combinational), so the X stage holds the instruction.
  - md_ready is ignored in IDLE.
- START (1 cycle):
  - md_ctrl_mult or md_ctrl_div = 1 per the latched op; exactly one pulse per operation.
  - Counter cleared; go to RUN.
- RUN:
  - Counter increments each cycle.
  - If md_ready:
    - md_exception=0: wb_rd = latched rd, wb_data = md_result.
    - md_exception=1: wb_rd = RSTATUS_REG, wb_data = EXC_MULT or EXC_DIV per op.
    - Go to DONE.
  - Else if counter == MAX_CYCLES-1: set timeout_err, wb_rd = RSTATUS_REG, wb_data = EXC_MULT/EXC_DIV, go to DONE.
  - md_ready on the same cycle as the timeout condition wins; it is a normal completion.
- DONE:
  - wb_valid = 1; wb_rd and wb_data are held stable.
  - On wb_accept: go to IDLE.
  - A new dx_start is not accepted in the same cycle; earliest re-accept is the next cycle.
- Writeback with rd=0: wb_rd=0 is still issued; the regfile discards it.
- stall:
  - stall = 1 in START, RUN, and in DONE while wb_accept=0.
  - stall = 0 in the DONE cycle where wb_accept=1.
- busy = (state != IDLE), registered.
- flush:
  - In any non-IDLE state, the next state is IDLE with wb_valid=0 and no writeback.
  - md_ctrl_* is not asserted in the cycle flush is seen.
  - A late md_ready arriving after the abort is ignored.
  - flush in IDLE blocks dx_start.
- Latency: dx_start at cycle T gives a start pulse at T+1. md_ready at cycle R gives wb_valid from R+1.
- md_op_a and md_op_b hold their values after completion until the next capture. They are not cleared by flush.

Decomposition:
- Shared package (multdiv_pkg) holds:
  - state enum localparams IDLE/START/RUN/DONE (2-bit encoding)
  - EXC_MULT, EXC_DIV, RSTATUS_REG defaults
  - op encoding (OP_MULT=0, OP_DIV=1)
- One natural sub-module: multdiv_timeout_ctr, an 8-bit clear/enable counter with a terminal-count compare to MAX_CYCLES-1.
- Operand and destination capture are plain registers in the top level.

Test Plan:
- Basic multiply:
  - Stimulus: dx_is_mult, a=7, b=6, rd=3; md_ready with result 42 on the 17th RUN cycle; wb_accept=1.
  - Response: one md_ctrl_mult pulse at T+1; wb_valid with rd=3, data=42; stall deasserts in the accept cycle; busy falls the next cycle.
- Divide by zero:
  - Stimulus: dx_is_div, a=10, b=0; md_ready with md_exception=1.
  - Response: wb_rd=30, wb_data=5, timeout_err=0.
- Writeback backpressure:
  - Stimulus: wb_accept held 0 for 4 cycles after DONE.
  - Response: wb_valid, wb_rd and wb_data stable for all 4 cycles; stall=1 throughout; exit on the first accept.
- Timeout:
  - Stimulus: MAX_CYCLES=40, md_ready never asserted during a multiply.
  - Response: DONE after 40 RUN cycles; wb_rd=30, wb_data=4; timeout_err=1 and sticky across the next operation.
- Flush mid-RUN:
  - Stimulus: flush at RUN cycle 5, then md_ready 3 cycles later.
  - Response: IDLE next cycle; no wb_valid; stall=0; the late md_ready has no effect.
- Reset mid-DONE:
  - Stimulus: reset_n=0 for one edge while wb_valid=1.
  - Response: all outputs 0, state IDLE; a back-to-back dx_start the next cycle is accepted normally.
